// File: rtl/vec_gather_if.sv
// Handshake and data bundle between a gather requester and vec_gather_unit.
// The master drives the request and memory image; the slave returns the packed vector.
interface vec_gather_if #(
    parameter int NUM_SIZE        = 16,
    parameter int WORDS_IN_MEMORY = 32,
    parameter int VEC_BUFFER_LEN  = 8
);
    localparam int AW = $clog2(WORDS_IN_MEMORY);
    localparam int LW = $clog2(VEC_BUFFER_LEN) + 1;

    logic                                 start;
    logic [AW-1:0]                        src_addr;
    logic [LW-1:0]                        length;
    logic [NUM_SIZE*WORDS_IN_MEMORY-1:0]  flat_memory;
    logic                                 ack;
    logic                                 busy;
    logic                                 vec_valid;
    logic [NUM_SIZE*VEC_BUFFER_LEN-1:0]   flat_vec_buffer;
    logic [LW-1:0]                        vec_length;
    logic                                 len_error;

    modport master (
        output start, src_addr, length, flat_memory, ack,
        input  busy, vec_valid, flat_vec_buffer, vec_length, len_error
    );

    modport slave (
        input  start, src_addr, length, flat_memory, ack,
        output busy, vec_valid, flat_vec_buffer, vec_length, len_error
    );
endinterface

// File: rtl/vec_gather_unit.sv
// Vector load engine: gathers a contiguous run of memory words, one per cycle,
// into a flat lane buffer and holds it until the consumer acknowledges.
module vec_gather_unit #(
    parameter int NUM_SIZE        = 16,
    parameter int WORDS_IN_MEMORY = 32,
    parameter int VEC_BUFFER_LEN  = 8
) (
    input logic         clk,
    input logic         rst,
    vec_gather_if.slave bus
);
    localparam int AW = $clog2(WORDS_IN_MEMORY);
    localparam int LW = $clog2(VEC_BUFFER_LEN) + 1;
    localparam int BW = NUM_SIZE * VEC_BUFFER_LEN;

    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

    state_t                state, state_nxt;
    logic [AW-1:0]         base;
    logic [LW-1:0]         offset;
    logic [LW-1:0]         vec_len;
    logic [BW-1:0]         vec_buf;
    logic                  len_err;
    logic [LW-1:0]         eff_len;
    logic [AW-1:0]         rd_addr;
    logic [NUM_SIZE-1:0]   rd_word;
    logic                  last_word;
    logic                  busy_q;
    logic                  valid_q;

    always_comb begin
        eff_len = bus.length;
        if (bus.length > LW'(VEC_BUFFER_LEN))
            eff_len = LW'(VEC_BUFFER_LEN);
    end

    // Address wraps by truncation to the memory index width.
    assign rd_addr   = base + AW'(offset);
    assign rd_word   = bus.flat_memory[int'(rd_addr)*NUM_SIZE +: NUM_SIZE];
    assign last_word = (offset == vec_len - 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start) state_nxt = (eff_len == '0) ? HOLD : LOAD;
            LOAD: if (last_word) state_nxt = HOLD;
            HOLD: if (bus.ack)   state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_q  = 1'b0;
        valid_q = 1'b0;
        case (state)
            LOAD:    busy_q = 1'b1;
            HOLD: begin
                busy_q  = 1'b1;
                valid_q = 1'b1;
            end
            default: ;
        endcase
    end

    // Buffer and length survive the ack; only a new start or reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base    <= '0;
            offset  <= '0;
            vec_len <= '0;
            vec_buf <= '0;
            len_err <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    base    <= bus.src_addr;
                    vec_len <= eff_len;
                    len_err <= (bus.length > LW'(VEC_BUFFER_LEN));
                    vec_buf <= '0;
                    offset  <= '0;
                end
                LOAD: begin
                    vec_buf[int'(offset)*NUM_SIZE +: NUM_SIZE] <= rd_word;
                    offset <= offset + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.vec_valid       = valid_q;
    assign bus.flat_vec_buffer = vec_buf;
    assign bus.vec_length      = vec_len;
    assign bus.len_error       = len_err;
endmodule

// File: tb/tb_vec_gather_unit.sv
// Directed bench for vec_gather_unit: the driver queues expected vectors,
// a negedge monitor compares them when vec_valid rises.
module tb_vec_gather_unit;
    localparam int NS = 16;
    localparam int WM = 32;
    localparam int VL = 8;

    typedef struct {
        logic [NS*VL-1:0] vec;
        logic [3:0]       len;
        logic             err;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   start_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t sb[$];

    vec_gather_if #(.NUM_SIZE(NS), .WORDS_IN_MEMORY(WM), .VEC_BUFFER_LEN(VL)) gif ();

    vec_gather_unit #(.NUM_SIZE(NS), .WORDS_IN_MEMORY(WM), .VEC_BUFFER_LEN(VL)) dut (
        .clk(clk),
        .rst(rst),
        .bus(gif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] lanes(input logic [15:0] l0, l1, l2, l3, l4, l5, l6, l7);
        return {l7, l6, l5, l4, l3, l2, l1, l0};
    endfunction

    // Monitor: each rising vec_valid consumes one queued expectation.
    always @(negedge clk) begin
        if (gif.vec_valid && !prev_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 128'd1, 128'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("vec_buffer", gif.flat_vec_buffer, e.vec);
                chk("vec_length", 128'(gif.vec_length), 128'(e.len));
                chk("len_error", 128'(gif.len_error), 128'(e.err));
                chk("latency", 128'(cyc - start_cyc + 1), 128'(e.lat));
            end
        end
        prev_valid <= gif.vec_valid;
    end

    task automatic set_word(input int p, input logic [15:0] v);
        gif.flat_memory[p*NS +: NS] = v;
    endtask

    task automatic push(input logic [127:0] v, input logic [3:0] l, input logic e, input int lat);
        exp_t x;
        x.vec = v; x.len = l; x.err = e; x.lat = lat;
        sb.push_back(x);
    endtask

    task automatic gather(input logic [4:0] a, input logic [3:0] l);
        @(posedge clk); #1;
        gif.start = 1'b1; gif.src_addr = a; gif.length = l;
        @(posedge clk); #1;
        start_cyc = cyc;
        gif.start = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        int k;
        k = 0;
        while (!gif.vec_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!gif.vec_valid) chk({nm, "_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic do_ack(input string nm, input logic [127:0] v);
        @(posedge clk); #1;
        gif.ack = 1'b1;
        @(posedge clk); #1;
        gif.ack = 1'b0;
        chk({nm, "_ack_busy"}, 128'(gif.busy), 128'd0);
        chk({nm, "_ack_valid"}, 128'(gif.vec_valid), 128'd0);
        chk({nm, "_ack_keep"}, gif.flat_vec_buffer, v);
    endtask

    initial begin
        logic [127:0] v;
        gif.start = 1'b0; gif.ack = 1'b0; gif.src_addr = '0; gif.length = '0;
        gif.flat_memory = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 128'(gif.busy), 128'd0);
        chk("rst_valid", 128'(gif.vec_valid), 128'd0);
        chk("rst_buf", gif.flat_vec_buffer, 128'd0);
        chk("rst_len", 128'(gif.vec_length), 128'd0);
        chk("rst_err", 128'(gif.len_error), 128'd0);
        @(negedge clk); rst = 1'b0;

        // Basic gather of four words.
        set_word(4, 16'h0011); set_word(5, 16'h0022); set_word(6, 16'h0033); set_word(7, 16'h0044);
        v = lanes(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 0, 0);
        push(v, 4'd4, 1'b0, 5);
        gather(5'd4, 4'd4);
        chk("basic_busy", 128'(gif.busy), 128'd1);
        wait_valid("basic");
        do_ack("basic", v);

        // Wrap-around from the top of memory.
        set_word(30, 16'hAAAA); set_word(31, 16'hBBBB); set_word(0, 16'hCCCC);
        v = lanes(16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 0, 0, 0, 0);
        push(v, 4'd3, 1'b0, 4);
        gather(5'd30, 4'd3);
        wait_valid("wrap");
        do_ack("wrap", v);

        // Zero length goes straight to HOLD with an empty buffer.
        push(128'd0, 4'd0, 1'b0, 1);
        gather(5'd4, 4'd0);
        wait_valid("len0");
        do_ack("len0", 128'd0);

        // Over-length request is clipped and flagged.
        for (int i = 0; i < 8; i++) set_word(8 + i, 16'h1000 + 16'(i));
        v = lanes(16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004, 16'h1005, 16'h1006, 16'h1007);
        push(v, 4'd8, 1'b1, 9);
        gather(5'd8, 4'd9);
        wait_valid("len9");
        do_ack("len9", v);
        chk("len9_err_sticky", 128'(gif.len_error), 128'd1);
        v = lanes(16'h0011, 0, 0, 0, 0, 0, 0, 0);
        push(v, 4'd1, 1'b0, 2);
        gather(5'd4, 4'd1);
        wait_valid("len1");
        do_ack("len1", v);

        // Misuse: start and ack while loading, start while holding, start+ack together.
        v = lanes(16'h0011, 16'h0022, 16'h0033, 16'h0044, 0, 0, 0, 0);
        push(v, 4'd4, 1'b0, 5);
        gather(5'd4, 4'd4);
        @(posedge clk); #1;
        gif.start = 1'b1; gif.src_addr = 5'd0; gif.length = 4'd1; gif.ack = 1'b1;
        @(posedge clk); #1;
        gif.start = 1'b0; gif.ack = 1'b0;
        chk("misuse_load_busy", 128'(gif.busy), 128'd1);
        chk("misuse_load_valid", 128'(gif.vec_valid), 128'd0);
        wait_valid("misuse");
        @(posedge clk); #1;
        gif.start = 1'b1; gif.src_addr = 5'd8; gif.length = 4'd2;
        @(posedge clk); #1;
        gif.start = 1'b0;
        chk("misuse_hold_valid", 128'(gif.vec_valid), 128'd1);
        chk("misuse_hold_len", 128'(gif.vec_length), 128'd4);
        @(posedge clk); #1;
        gif.start = 1'b1; gif.ack = 1'b1;
        @(posedge clk); #1;
        gif.start = 1'b0; gif.ack = 1'b0;
        chk("both_valid", 128'(gif.vec_valid), 128'd0);
        @(posedge clk); #1;
        chk("both_no_restart", 128'(gif.busy), 128'd0);
        chk("both_keep", gif.flat_vec_buffer, v);

        // Reset in the middle of a gather discards it.
        gather(5'd8, 4'd6);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(gif.busy), 128'd0);
        chk("midrst_valid", 128'(gif.vec_valid), 128'd0);
        chk("midrst_buf", gif.flat_vec_buffer, 128'd0);
        chk("midrst_len", 128'(gif.vec_length), 128'd0);
        @(negedge clk); rst = 1'b0;
        v = lanes(16'h1000, 16'h1001, 0, 0, 0, 0, 0, 0);
        push(v, 4'd2, 1'b0, 3);
        gather(5'd8, 4'd2);
        wait_valid("postrst");
        do_ack("postrst", v);

        // Live sampling: memory[3] changes just before lane 3 is read.
        set_word(0, 16'h00A0); set_word(1, 16'h00A1); set_word(2, 16'h00A2); set_word(3, 16'h0001);
        v = lanes(16'h00A0, 16'h00A1, 16'h00A2, 16'h0002, 0, 0, 0, 0);
        push(v, 4'd4, 1'b0, 5);
        gather(5'd0, 4'd4);
        repeat (3) @(posedge clk);
        #1;
        set_word(3, 16'h0002);
        wait_valid("live");
        do_ack("live", v);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_gather_unit.md
# vec_gather_unit

Vector load engine for the accelerator: the reader counterpart of the vector-buffer copy-back path. On a start request it reads a contiguous run of words from the flattened data memory, one word per cycle, and packs them into a flat vector buffer for the VPU. It then holds the result until the consumer acknowledges it. It sits between the memory array (via `flat_memory`) and the VPU operand inputs.

## Interface
- `NUM_SIZE`, 16: bits per word.
- `WORDS_IN_MEMORY`, 32: words in memory; must be a power of two.
- `VEC_BUFFER_LEN`, 8: lanes in the vector buffer.
- `clk` in 1: clock, all state updates on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: request a gather; sampled only in IDLE.
- `src_addr` in $clog2(WORDS_IN_MEMORY): first word address.
- `length` in $clog2(VEC_BUFFER_LEN)+1: words to gather, 0..VEC_BUFFER_LEN legal.
- `flat_memory` in NUM_SIZE*WORDS_IN_MEMORY: word p occupies bits [(p+1)*NUM_SIZE-1 : p*NUM_SIZE].
- `ack` in 1: consumer has taken the vector; honoured only in HOLD.
- `busy` out 1: high in LOAD and HOLD.
- `vec_valid` out 1: high in HOLD only.
- `flat_vec_buffer` out NUM_SIZE*VEC_BUFFER_LEN: lane q occupies bits [(q+1)*NUM_SIZE-1 : q*NUM_SIZE].
- `vec_length` out $clog2(VEC_BUFFER_LEN)+1: lanes actually loaded.
- `len_error` out 1: requested length exceeded VEC_BUFFER_LEN; sticky until the next accepted start.

## Operation
- States: IDLE, LOAD, HOLD. Reset puts the block in IDLE and clears every output to 0: `busy`, `vec_valid`, `flat_vec_buffer`, `vec_length`, `len_error`. Internal offset and address registers also clear.
- IDLE with `start`=1:
  - Latch `src_addr` as the base address.
  - Latch the effective length: min(`length`, VEC_BUFFER_LEN), into `vec_length`.
  - Set `len_error` if `length` > VEC_BUFFER_LEN, otherwise clear it.
  - Clear all of `flat_vec_buffer` and set offset to 0.
  - If the effective length is 0, go to HOLD; otherwise go to LOAD.
- LOAD, each cycle:
  - Lane[offset] gets memory[(base+offset) mod WORDS_IN_MEMORY]. Addresses wrap with natural truncation, so base 30 with length 4 reads 30, 31, 0, 1.
  - Increment offset.
  - When offset == effective length − 1, write that word and go to HOLD.
- Lanes at or above the effective length stay 0.
- Memory is sampled live on each LOAD cycle. A change to a word before its read cycle is captured; a change after its read cycle is not.
- HOLD:
  - `flat_vec_buffer` and `vec_length` are stable.
  - `ack`=1 moves the block to IDLE. The buffer contents and `vec_length` are retained; only `vec_valid` and `busy` drop.
- `start` in LOAD or HOLD is ignored, with no queueing.
- `ack` in IDLE or LOAD is ignored.
- Simultaneous `start` and `ack` in HOLD: `ack` is taken and `start` is ignored. The requester must re-assert `start` in IDLE.
- `rst` asserted mid-LOAD or in HOLD: immediate return to IDLE with all outputs cleared. The partial vector is discarded.

## Timing
- Gather of L ≥ 1 words, with `start` sampled at edge E0:
  - `busy` is high after E0.
  - Lane k is written at edge E(k+1).
  - `vec_valid` rises after edge EL, giving start-to-valid latency of L+1 cycles.
- L = 0: `vec_valid` is high after E0 (1 cycle).
- `ack` sampled at edge Ea: `vec_valid` and `busy` are low after Ea. A new `start` can be accepted at edge Ea+1 at the earliest.
- Throughput: one word per cycle.
- Back-to-back gathers of L words take L+2 cycles each.
- All outputs are registered; there are no combinational paths from input to output.

## Test plan
- Reset, then preload memory[4..7] = 0x0011, 0x0022, 0x0033, 0x0044 and start with `src_addr`=4, `length`=4.
  - Required: `vec_valid` high exactly 5 cycles after start.
  - Required: lanes 0..3 = 0x0011..0x0044, lanes 4..7 = 0, `vec_length`=4, `len_error`=0.
  - Then `ack`: `busy` and `vec_valid` drop the next cycle, and the buffer is unchanged.
- Wrap-around: memory[30]=0xAAAA, memory[31]=0xBBBB, memory[0]=0xCCCC; start with `src_addr`=30, `length`=3.
  - Required: lanes 0..2 = 0xAAAA, 0xBBBB, 0xCCCC, and `vec_valid` after 4 cycles.
- Length boundaries:
  - `length`=0: `vec_valid` one cycle after start, buffer all zero, `vec_length`=0.
  - `length`=9: 8 words loaded, `vec_length`=8, `len_error`=1.
  - A following legal start clears `len_error`.
- Protocol misuse:
  - `start` pulsed during LOAD and during HOLD is ignored.
  - `ack` during LOAD does not end the gather.
  - `start` and `ack` together in HOLD: return to IDLE with no new gather.
- Reset mid-LOAD: assert `rst` after 2 words of a length-6 gather.
  - Required: all outputs 0 immediately.
  - Required: a subsequent gather of `length`=2 from address 8 completes correctly in 3 cycles.
- Live sampling: during a length-4 gather from address 0, change memory[3] from 0x0001 to 0x0002 one cycle before lane 3 is read.
  - Required: lane 3 = 0x0002.
